// File: rtl/lnet_pkg.sv
// Shared definitions for the LSTM datapath bias-add stage.
// Holds default geometry, the FSM state encoding and lane-packing helpers.
// Configuration macro: BIAS_SAT_EN (defined = saturating narrowing, undefined = wrap).
package lnet_pkg;

  localparam int D_WL_DEF      = 24;
  localparam int ACC_WL_DEF    = 32;
  localparam int UNITS_NUM_DEF = 5;
  localparam int ROWS_DEF      = 6;
  localparam int ADDR_WL       = 8;

`ifdef BIAS_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bit offset of lane k in a vector packed with lanes of width wl.
  function automatic int lane_lo(input int k, input int wl);
    return k * wl;
  endfunction

endpackage

// File: rtl/bias_sat_lane.sv
// One unit of the bias-add: sign-extended add of accumulator and bias, then
// narrowing to D_WL (clamp when BIAS_SAT_EN is defined, two's-complement wrap otherwise).
// Ports: i_acc (ACC_WL signed), i_bias (D_WL signed), o_res (D_WL signed), o_sat (clamp applied).
// Purely combinational; no latency, no flow control.
module bias_sat_lane
  import lnet_pkg::*;
#(
  parameter int D_WL   = D_WL_DEF,
  parameter int ACC_WL = ACC_WL_DEF
) (
  input  logic [ACC_WL-1:0] i_acc,
  input  logic [D_WL-1:0]   i_bias,
  output logic [D_WL-1:0]   o_res,
  output logic              o_sat
);

  logic [ACC_WL:0]      w_sum;
  logic [ACC_WL-D_WL+1:0] w_top;
  logic                 w_ovf;
  logic [D_WL-1:0]      w_max;
  logic [D_WL-1:0]      w_min;

  // One extra bit of headroom means the add itself can never overflow.
  assign w_sum = {i_acc[ACC_WL-1], i_acc}
               + {{(ACC_WL+1-D_WL){i_bias[D_WL-1]}}, i_bias};

  // The sum fits in D_WL bits only if every bit from the D_WL sign bit up
  // is a copy of the true sign.
  assign w_top = w_sum[ACC_WL:D_WL-1];
  assign w_ovf = !((&w_top) || !(|w_top));

  assign w_max = {1'b0, {(D_WL-1){1'b1}}};
  assign w_min = {1'b1, {(D_WL-1){1'b0}}};

  // SAT_EN is a build constant; in wrap builds the clamp path folds away.
  assign o_sat = SAT_EN && w_ovf;
  assign o_res = o_sat ? (w_sum[ACC_WL] ? w_min : w_max) : w_sum[D_WL-1:0];

endmodule

// File: rtl/bias_add_seq.sv
// Row-sequenced bias-add: addresses the bias ROM by row, adds bias to each
// accumulator unit, narrows to D_WL and presents a registered valid/ready result.
// Latency 1 cycle from input transfer; acc_ready drops while a result is stalled.
// Ports: clk/rst (async active-high); start; acc_valid/acc_ready/acc_i input stream;
//   bias_addr/bias_i ROM lookup; out_valid/out_ready/out_o/row_o/last_o result stream;
//   done frame-end pulse; sat_flag sticky clamp indicator.
// Configuration macro: BIAS_SAT_EN (defined = saturate and flag, undefined = wrap, flag 0).
module bias_add_seq
  import lnet_pkg::*;
#(
  parameter int D_WL      = D_WL_DEF,
  parameter int ACC_WL    = ACC_WL_DEF,
  parameter int UNITS_NUM = UNITS_NUM_DEF,
  parameter int ROWS      = ROWS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        acc_valid,
  output logic                        acc_ready,
  input  logic [UNITS_NUM*ACC_WL-1:0] acc_i,
  output logic [ADDR_WL-1:0]          bias_addr,
  input  logic [UNITS_NUM*D_WL-1:0]   bias_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UNITS_NUM*D_WL-1:0]   out_o,
  output logic [ADDR_WL-1:0]          row_o,
  output logic                        last_o,
  output logic                        done,
  output logic                        sat_flag
);

  localparam logic [ADDR_WL-1:0] LAST_ROW = ADDR_WL'(ROWS - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [ADDR_WL-1:0]          r_row_cnt;
  logic                        r_out_valid;
  logic [UNITS_NUM*D_WL-1:0]   r_out;
  logic [ADDR_WL-1:0]          r_row;
  logic                        r_last;
  logic                        r_done;
  logic                        r_sat;

  logic                        w_acc_ready;
  logic                        w_xfer;
  logic                        w_last_row;
  logic [UNITS_NUM*D_WL-1:0]   w_sum_vec;
  logic [UNITS_NUM-1:0]        w_lane_sat;

  // Per-unit add/narrow lanes.
  for (genvar k = 0; k < UNITS_NUM; k++) begin : g_lane
    bias_sat_lane #(
      .D_WL  (D_WL),
      .ACC_WL(ACC_WL)
    ) u_lane (
      .i_acc (acc_i[lane_lo(k, ACC_WL) +: ACC_WL]),
      .i_bias(bias_i[lane_lo(k, D_WL) +: D_WL]),
      .o_res (w_sum_vec[lane_lo(k, D_WL) +: D_WL]),
      .o_sat (w_lane_sat[k])
    );
  end

  // Ready depends only on registered state and out_ready, never on acc_valid.
  assign w_acc_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_xfer      = acc_valid && w_acc_ready;
  assign w_last_row  = (r_row_cnt == LAST_ROW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_xfer && w_last_row) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_row       <= '0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last_row;

      if ((r_state == ST_IDLE) && start) begin
        r_row_cnt <= '0;
        r_sat     <= 1'b0;
      end else if (w_xfer) begin
        r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
        r_sat     <= r_sat | (|w_lane_sat);
      end

      // A new transfer wins over a drain so back-to-back rows keep valid high.
      if (w_xfer) begin
        r_out       <= w_sum_vec;
        r_row       <= r_row_cnt;
        r_last      <= w_last_row;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign acc_ready = w_acc_ready;
  assign bias_addr = r_row_cnt;
  assign out_valid = r_out_valid;
  assign out_o     = r_out;
  assign row_o     = r_row;
  assign last_o    = r_last;
  assign done      = r_done;
  assign sat_flag  = r_sat;

endmodule

// File: tb/tb_bias_add_seq.sv
module tb_bias_add_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         acc_valid;
  logic         acc_ready;
  logic [159:0] acc_i;
  logic [7:0]   bias_addr;
  logic [119:0] bias_i;
  logic         out_valid;
  logic         out_ready;
  logic [119:0] out_o;
  logic [7:0]   row_o;
  logic         last_o;
  logic         done;
  logic         sat_flag;

  int errors = 0;
  int checks = 0;

  logic [119:0] rom [6];

  always #5 clk = ~clk;

  always_comb begin
    bias_i = '0;
    if (bias_addr < 8'd6) bias_i = rom[bias_addr[2:0]];
  end

  bias_add_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .acc_valid(acc_valid),
    .acc_ready(acc_ready),
    .acc_i    (acc_i),
    .bias_addr(bias_addr),
    .bias_i   (bias_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_o    (out_o),
    .row_o    (row_o),
    .last_o   (last_o),
    .done     (done),
    .sat_flag (sat_flag)
  );

`ifdef BIAS_SAT_EN
  localparam logic [23:0] EXP_POS = 24'h7FFFFF;
  localparam logic [23:0] EXP_NEG = 24'h800000;
  localparam logic        EXP_SAT = 1'b1;
`else
  localparam logic [23:0] EXP_POS = 24'h000000;
  localparam logic [23:0] EXP_NEG = 24'h7FFFFF;
  localparam logic        EXP_SAT = 1'b0;
`endif

  function automatic logic [159:0] mk_acc(input logic [31:0] u0, input logic [31:0] u1);
    return {96'd0, u1, u0};
  endfunction

  function automatic logic [119:0] mk_out(input logic [23:0] u0, input logic [23:0] u1);
    return {72'd0, u1, u0};
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] exp_u0 [6];
    exp_u0[0] = 24'h10; exp_u0[1] = 24'h20; exp_u0[2] = 24'h1F;
    exp_u0[3] = 24'h35; exp_u0[4] = 24'h45; exp_u0[5] = 24'h55;

    rom[0] = mk_out(24'h000010, 24'h000001);
    rom[1] = mk_out(24'h000010, 24'h0);
    rom[2] = mk_out(24'hFFFFFF, 24'h0);
    rom[3] = mk_out(24'h000005, 24'h0);
    rom[4] = mk_out(24'h000005, 24'h0);
    rom[5] = mk_out(24'h000005, 24'h0);

    rst = 1'b1; start = 1'b0; acc_valid = 1'b0; out_ready = 1'b1; acc_i = '0;
    tick(); tick();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_ready", acc_ready, 0);
    check("rst_bias_addr", bias_addr, 0);
    check("rst_out_o", out_o, 0);
    check("rst_row_o", row_o, 0);
    check("rst_last_o", last_o, 0);
    check("rst_done", done, 0);
    check("rst_sat_flag", sat_flag, 0);

    rst = 1'b0;
    tick();
    check("idle_acc_ready", acc_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("run_acc_ready", acc_ready, 1);
    check("run_bias_addr0", bias_addr, 0);

    // Row 0 basic add
    acc_i = mk_acc(32'h00000100, 32'h7); acc_valid = 1'b1;
    check("pre_xfer_valid", out_valid, 0);
    tick(); acc_valid = 1'b0;
    check("r0_out_valid", out_valid, 1);
    check("r0_out_o", out_o, mk_out(24'h000110, 24'h000008));
    check("r0_row_o", row_o, 0);
    check("r0_last_o", last_o, 0);
    check("r0_bias_addr", bias_addr, 1);
    tick();
    check("r0_drained", out_valid, 0);

    // Row 1 positive overflow
    acc_i = mk_acc(32'h7FFFFFF0, 32'h0); acc_valid = 1'b1;
    tick(); acc_valid = 1'b0;
    check("pos_ovf_out", out_o, mk_out(EXP_POS, 24'h0));
    check("pos_ovf_sat", sat_flag, EXP_SAT);
    tick();

    // Row 2 negative overflow
    acc_i = mk_acc(32'hFF800000, 32'h0); acc_valid = 1'b1;
    tick(); acc_valid = 1'b0;
    check("neg_ovf_out", out_o, mk_out(EXP_NEG, 24'h0));
    check("neg_ovf_sat", sat_flag, EXP_SAT);
    check("neg_ovf_row", row_o, 2);
    tick();
    check("r2_drained", out_valid, 0);

    // Backpressure on row 3
    out_ready = 1'b0;
    acc_i = mk_acc(32'h1, 32'h0); acc_valid = 1'b1;
    tick();
    acc_i = mk_acc(32'h2, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_acc_ready", acc_ready, 0);
      check("bp_out_o", out_o, mk_out(24'h6, 24'h0));
      check("bp_row_o", row_o, 3);
      check("bp_valid", out_valid, 1);
      check("bp_bias_addr", bias_addr, 4);
      tick();
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", acc_ready, 1);
    tick();
    check("r4_out_o", out_o, mk_out(24'h7, 24'h0));
    check("r4_row_o", row_o, 4);
    check("r4_valid", out_valid, 1);
    acc_i = mk_acc(32'h3, 32'h0);
    tick(); acc_valid = 1'b0;
    check("r5_out_o", out_o, mk_out(24'h8, 24'h0));
    check("r5_row_o", row_o, 5);
    check("r5_last_o", last_o, 1);
    check("r5_done", done, 1);
    check("r5_idle_ready", acc_ready, 0);
    check("r5_bias_addr", bias_addr, 0);
    tick();
    check("done_clear", done, 0);
    check("end_valid", out_valid, 0);

    // Frame of 6 back-to-back rows
    start = 1'b1; tick(); start = 1'b0;
    check("f_sat_cleared", sat_flag, 0);
    for (int r = 0; r < 6; r++) begin
      check("f_bias_addr", bias_addr, r);
      acc_i = mk_acc(32'(r * 16), 32'h0); acc_valid = 1'b1;
      tick();
      check("f_row_o", row_o, r);
      check("f_last_o", last_o, (r == 5));
      check("f_done", done, (r == 5));
      check("f_out_o", out_o, mk_out(exp_u0[r], (r == 0) ? 24'h1 : 24'h0));
    end
    acc_valid = 1'b0;
    check("f_end_ready", acc_ready, 0);
    check("f_end_addr", bias_addr, 0);
    tick();
    check("f_done_once", done, 0);
    check("f_still_idle", acc_ready, 0);

    // Reset mid-frame at row 3 with a pending result
    start = 1'b1; tick(); start = 1'b0;
    acc_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      acc_i = (r == 1) ? mk_acc(32'h7FFFFFF0, 32'h0) : mk_acc(32'h0, 32'h0);
      tick();
    end
    acc_valid = 1'b0;
    check("mr_row_o", row_o, 3);
    check("mr_valid", out_valid, 1);
    check("mr_sat", sat_flag, EXP_SAT);
    rst = 1'b1;
    tick();
    check("mr_rst_valid", out_valid, 0);
    check("mr_rst_out_o", out_o, 0);
    check("mr_rst_row_o", row_o, 0);
    check("mr_rst_last", last_o, 0);
    check("mr_rst_addr", bias_addr, 0);
    check("mr_rst_ready", acc_ready, 0);
    check("mr_rst_sat", sat_flag, 0);
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("rs_bias_addr", bias_addr, 0);
    check("rs_sat", sat_flag, 0);
    check("rs_ready", acc_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
